// File: rtl/button_debouncer_pkg.sv
// Shared defaults, button index constants and per-channel output payload
// for the panel button conditioning front end.
package button_debouncer_pkg;

    localparam int unsigned CLK_HZ           = 100_000_000;
    localparam int unsigned DEF_NUM_BTN      = 5;
    localparam int unsigned DEF_DEBOUNCE_CYC = 2_000_000;
    localparam int unsigned DEF_LONG_CYC     = 300_000_000;

    localparam int unsigned BTN_A = 0;
    localparam int unsigned BTN_S = 1;
    localparam int unsigned BTN_W = 2;
    localparam int unsigned BTN_X = 3;
    localparam int unsigned BTN_D = 4;

    typedef enum logic {
        LVL_LOW  = 1'b0,
        LVL_HIGH = 1'b1
    } level_e;

    typedef struct packed {
        logic level;
        logic pos;
        logic neg;
        logic lng;
    } chan_out_t;

    // Counter width able to hold 0..n-1, never zero bits wide.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One button: 2-FF synchroniser, debounce level state with edge pulses,
// and a long-press detector that fires once per press.
module button_debouncer_channel
    import button_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEF_LONG_CYC
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      btn_in,
    output chan_out_t ch_out
);

    localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYC);
    localparam int unsigned LP_W = cnt_width(LONG_CYC);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_CYC - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    level_e          level_q, level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            pos_q, pos_d;
    logic            neg_q, neg_d;
    logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
    logic            fired_q, fired_d;
    logic            long_q, long_d;
    logic            level_hi;

    assign level_hi = (level_q == LVL_HIGH);

    // Next-state: level only moves after DEBOUNCE_CYC consecutive disagreeing samples.
    always_comb begin
        sync1_d  = btn_in;
        sync2_d  = sync1_q;
        level_d  = level_q;
        db_cnt_d = '0;
        pos_d    = 1'b0;
        neg_d    = 1'b0;
        lp_cnt_d = '0;
        fired_d  = 1'b0;
        long_d   = 1'b0;

        if (sync2_q != level_hi) begin
            if (db_cnt_q == DB_MAX) begin
                level_d = sync2_q ? LVL_HIGH : LVL_LOW;
                pos_d   = sync2_q;
                neg_d   = ~sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        // Once fired the counter parks at zero until the level drops.
        if (level_hi) begin
            fired_d = fired_q;
            if (!fired_q) begin
                if (lp_cnt_q == LP_MAX) begin
                    long_d  = 1'b1;
                    fired_d = 1'b1;
                end else begin
                    lp_cnt_d = lp_cnt_q + LP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= LVL_LOW;
            db_cnt_q <= '0;
            pos_q    <= 1'b0;
            neg_q    <= 1'b0;
            lp_cnt_q <= '0;
            fired_q  <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
            pos_q    <= pos_d;
            neg_q    <= neg_d;
            lp_cnt_q <= lp_cnt_d;
            fired_q  <= fired_d;
            long_q   <= long_d;
        end
    end

    assign ch_out.level = level_hi;
    assign ch_out.pos   = pos_q;
    assign ch_out.neg   = neg_q;
    assign ch_out.lng   = long_q;

endmodule

// File: rtl/button_debouncer.sv
// Panel button front end: NUM_BTN independent debounce channels feeding
// clean levels and edge / long-press pulses to the control logic.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned NUM_BTN      = DEF_NUM_BTN,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEF_LONG_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] pos_pulse,
    output logic [NUM_BTN-1:0] neg_pulse,
    output logic [NUM_BTN-1:0] long_pulse
);

    for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_chan
        chan_out_t ch;

        button_debouncer_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .btn_in (btn_in[i]),
            .ch_out (ch)
        );

        assign btn_level[i]  = ch.level;
        assign pos_pulse[i]  = ch.pos;
        assign neg_pulse[i]  = ch.neg;
        assign long_pulse[i] = ch.lng;
    end

endmodule
